// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the program/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    localparam int MEM_WAIT_DEFAULT = 2;
    localparam int CTR_W            = $clog2(16);

    function automatic logic [15:0] store_word(input logic [7:0] b);
        return {8'h00, b};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
interface mem_arb_if #(
    parameter int ADDR_W = 16
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;
    logic [15:0]       instr;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [7:0]        data_wdata;
    logic              data_ack;
    logic [7:0]        load_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              busy;
    logic              pc_hold;

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, mem_rdata,
        output fetch_ack, instr, data_ack, load_data, mem_addr, mem_re, mem_we, mem_wdata,
               busy, pc_hold
    );

    modport master (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, mem_rdata,
        input  fetch_ack, instr, data_ack, load_data, mem_addr, mem_re, mem_we, mem_wdata,
               busy, pc_hold
    );

endinterface

// File: rtl/mem_port_arbiter_wait_ctr.sv
// Loadable down-counter that times one memory access; zero_o marks its last cycle.
module mem_wait_ctr
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = CTR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto the single shared memory,
// data first, one fixed-latency access at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_WAIT = MEM_WAIT_DEFAULT,
    parameter int ADDR_W   = 16
) (
    input  logic    clk,
    input  logic    rst,
    mem_arb_if.slave bus
);

    if ((MEM_WAIT < 1) || (MEM_WAIT > 15)) begin : g_bad_wait
        $error("mem_port_arbiter: MEM_WAIT must be within 1..15");
    end

    localparam logic [CTR_W-1:0] WAIT_LOAD = CTR_W'(MEM_WAIT - 1);

    arb_state_e        state_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [15:0]       mem_wdata_q;
    logic              fetch_ack_q;
    logic              data_ack_q;
    logic [15:0]       instr_q;
    logic [7:0]        load_data_q;

    logic grant;
    logic last_cycle;

    // The cycle carrying an ack is dead: the requester still shows its old request.
    assign grant = (state_q == IDLE) && !(fetch_ack_q || data_ack_q) &&
                   (bus.data_req || bus.fetch_req);

    mem_wait_ctr #(
        .WIDTH(CTR_W)
    ) u_wait_ctr (
        .clk       (clk),
        .rst       (rst),
        .load_i    (grant),
        .load_val_i(WAIT_LOAD),
        .dec_i     (state_q != IDLE),
        .zero_o    (last_cycle)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 16'h0000;
            fetch_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            instr_q     <= 16'h0000;
            load_data_q <= 8'h00;
        end else begin
            fetch_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant && bus.data_req) begin
                        state_q     <= DATA;
                        mem_addr_q  <= bus.data_addr;
                        mem_re_q    <= ~bus.data_we;
                        mem_we_q    <= bus.data_we;
                        mem_wdata_q <= bus.data_we ? store_word(bus.data_wdata) : 16'h0000;
                    end else if (grant) begin
                        state_q     <= FETCH;
                        mem_addr_q  <= bus.fetch_addr;
                        mem_re_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= 16'h0000;
                    end
                end
                FETCH: begin
                    if (last_cycle) begin
                        instr_q     <= bus.mem_rdata;
                        fetch_ack_q <= 1'b1;
                        mem_re_q    <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                DATA: begin
                    if (last_cycle) begin
                        // mem_re_q still holds the latched load/store choice here.
                        if (mem_re_q) begin
                            load_data_q <= bus.mem_rdata[7:0];
                        end
                        data_ack_q  <= 1'b1;
                        mem_re_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= 16'h0000;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.fetch_ack = fetch_ack_q;
    assign bus.data_ack  = data_ack_q;
    assign bus.instr     = instr_q;
    assign bus.load_data = load_data_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.pc_hold   = bus.fetch_req & ~fetch_ack_q;

endmodule
